vram_request_arbiter: RTL and testbench

//  Parametrised VRAM access arbiter between N video clients and the single memory_controller.

---
 rtl/vram_request_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_vram_request_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_request_arbiter.sv
// Round-robin VRAM arbiter: N clients plus a periodic refresh share one memory controller.
// Refresh has deadline priority; missing a whole refresh interval sets a sticky overrun flag.
module vram_request_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int MASK_W      = 4,
  parameter int REFRESH_INT = 840
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        cl_req,
  input  logic [NUM_CLIENTS-1:0]        cl_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
  input  logic [NUM_CLIENTS*MASK_W-1:0] cl_wmask,
  output logic [NUM_CLIENTS-1:0]        cl_ack,
  output logic [DATA_W-1:0]             cl_rdata,
  output logic                          mc_read,
  output logic                          mc_write,
  output logic                          mc_refresh,
  output logic [ADDR_W-1:0]             mc_addr,
  output logic [DATA_W-1:0]             mc_din,
  output logic [MASK_W-1:0]             mc_wdm,
  input  logic                          mc_busy,
  input  logic [DATA_W-1:0]             mc_dout,
  output logic                          refresh_overrun
);

  localparam int ID_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = $clog2(REFRESH_INT);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   we_q, we_d;
  logic                   is_ref_q, is_ref_d;
  logic [1:0]             wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]       ref_cnt_q, ref_cnt_d;
  logic                   ref_pend_q, ref_pend_d;
  logic                   overrun_q, overrun_d;
  logic                   mc_read_q, mc_read_d;
  logic                   mc_write_q, mc_write_d;
  logic                   mc_refresh_q, mc_refresh_d;
  logic [ADDR_W-1:0]      mc_addr_q, mc_addr_d;
  logic [DATA_W-1:0]      mc_din_q, mc_din_d;
  logic [MASK_W-1:0]      mc_wdm_q, mc_wdm_d;
  logic [NUM_CLIENTS-1:0] cl_ack_q, cl_ack_d;
  logic [DATA_W-1:0]      cl_rdata_q, cl_rdata_d;

  logic [ADDR_W-1:0] addr_a  [NUM_CLIENTS];
  logic [DATA_W-1:0] wdata_a [NUM_CLIENTS];
  logic [MASK_W-1:0] wmask_a [NUM_CLIENTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign addr_a[gi]  = cl_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_a[gi] = cl_wdata[gi*DATA_W +: DATA_W];
      assign wmask_a[gi] = cl_wmask[gi*MASK_W +: MASK_W];
    end
  endgenerate

  // A client whose ack is showing this cycle is ignored so it can drop req without a re-grant.
  logic [NUM_CLIENTS-1:0] req_eff;
  logic [ID_W-1:0]        grant_id;
  logic                   grant_found;
  logic [ID_W:0]          rr_sum;

  assign req_eff = cl_req & ~cl_ack_q;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_q;
    rr_sum      = '0;
    // Descending scan so the nearest index at or after the pointer wins.
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_q} + (ID_W+1)'(k);
      if (rr_sum >= (ID_W+1)'(NUM_CLIENTS)) rr_sum = rr_sum - (ID_W+1)'(NUM_CLIENTS);
      if (req_eff[rr_sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = rr_sum[ID_W-1:0];
      end
    end
  end

  logic ref_wrap;
  logic issuing_ref;

  assign ref_wrap    = (ref_cnt_q == CNT_W'(REFRESH_INT - 1));
  assign issuing_ref = (state_q == ST_ISSUE) && is_ref_q;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    we_d         = we_q;
    is_ref_d     = is_ref_q;
    wait_cnt_d   = wait_cnt_q;
    mc_addr_d    = mc_addr_q;
    mc_din_d     = mc_din_q;
    mc_wdm_d     = mc_wdm_q;
    cl_rdata_d   = cl_rdata_q;
    mc_read_d    = 1'b0;
    mc_write_d   = 1'b0;
    mc_refresh_d = 1'b0;
    cl_ack_d     = '0;

    ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + CNT_W'(1);
    ref_pend_d = ref_wrap ? 1'b1 : (issuing_ref ? 1'b0 : ref_pend_q);
    overrun_d  = overrun_q | (ref_wrap & ref_pend_q & ~issuing_ref);

    case (state_q)
      ST_IDLE: begin
        if (!mc_busy) begin
          if (ref_pend_q) begin
            is_ref_d     = 1'b1;
            mc_refresh_d = 1'b1;
            state_d      = ST_ISSUE;
          end else if (grant_found) begin
            is_ref_d   = 1'b0;
            id_d       = grant_id;
            we_d       = cl_we[grant_id];
            mc_read_d  = ~cl_we[grant_id];
            mc_write_d = cl_we[grant_id];
            mc_addr_d  = addr_a[grant_id];
            mc_din_d   = wdata_a[grant_id];
            mc_wdm_d   = wmask_a[grant_id];
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A controller that never raises busy is treated as having finished after 4 cycles.
        if (mc_busy || wait_cnt_q == 2'd3) state_d = ST_WAIT_DONE;
        else wait_cnt_d = wait_cnt_q + 2'd1;
      end
      default: begin
        if (!mc_busy) begin
          state_d = ST_IDLE;
          if (!is_ref_q) begin
            cl_ack_d[id_q] = 1'b1;
            if (!we_q) cl_rdata_d = mc_dout;
            rr_d = (id_q == ID_W'(NUM_CLIENTS - 1)) ? '0 : id_q + ID_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      we_q         <= 1'b0;
      is_ref_q     <= 1'b0;
      wait_cnt_q   <= '0;
      ref_cnt_q    <= '0;
      ref_pend_q   <= 1'b0;
      overrun_q    <= 1'b0;
      mc_read_q    <= 1'b0;
      mc_write_q   <= 1'b0;
      mc_refresh_q <= 1'b0;
      mc_addr_q    <= '0;
      mc_din_q     <= '0;
      mc_wdm_q     <= '0;
      cl_ack_q     <= '0;
      cl_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      we_q         <= we_d;
      is_ref_q     <= is_ref_d;
      wait_cnt_q   <= wait_cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_pend_q   <= ref_pend_d;
      overrun_q    <= overrun_d;
      mc_read_q    <= mc_read_d;
      mc_write_q   <= mc_write_d;
      mc_refresh_q <= mc_refresh_d;
      mc_addr_q    <= mc_addr_d;
      mc_din_q     <= mc_din_d;
      mc_wdm_q     <= mc_wdm_d;
      cl_ack_q     <= cl_ack_d;
      cl_rdata_q   <= cl_rdata_d;
    end
  end

  assign cl_ack          = cl_ack_q;
  assign cl_rdata        = cl_rdata_q;
  assign mc_read         = mc_read_q;
  assign mc_write        = mc_write_q;
  assign mc_refresh      = mc_refresh_q;
  assign mc_addr         = mc_addr_q;
  assign mc_din          = mc_din_q;
  assign mc_wdm          = mc_wdm_q;
  assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_vram_request_arbiter.sv
// Directed bench for vram_request_arbiter with a 3-cycle busy controller stub.
module tb_vram_request_arbiter;
  localparam int N  = 2;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  cl_req, cl_we;
  logic [N*AW-1:0] cl_addr;
  logic [N*DW-1:0] cl_wdata;
  logic [N*MW-1:0] cl_wmask;
  logic [N-1:0]  cl_ack;
  logic [DW-1:0] cl_rdata;
  logic          mc_read, mc_write, mc_refresh;
  logic [AW-1:0] mc_addr;
  logic [DW-1:0] mc_din;
  logic [MW-1:0] mc_wdm;
  logic          mc_busy;
  logic [DW-1:0] mc_dout;
  logic          refresh_overrun;

  vram_request_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .REFRESH_INT(840)) dut (
    .clk(clk), .reset(reset),
    .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr), .cl_wdata(cl_wdata), .cl_wmask(cl_wmask),
    .cl_ack(cl_ack), .cl_rdata(cl_rdata),
    .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh),
    .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm),
    .mc_busy(mc_busy), .mc_dout(mc_dout), .refresh_overrun(refresh_overrun)
  );

  // Controller stub: busy for 3 cycles after any strobe, or held high by busy_force.
  logic        busy_force = 1'b0;
  int          busy_cnt = 0;
  logic [31:0] stub_dout = '0;
  assign mc_busy = busy_force || (busy_cnt != 0);
  assign mc_dout = stub_dout;
  always @(posedge clk) begin
    if (mc_read || mc_write || mc_refresh) busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_count = 0;
  logic [N-1:0] last_ack = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cl_ack != '0) begin
      ack_count++;
      last_ack = cl_ack;
    end
  endtask

  task automatic wait_refresh(output int c);
    logic found = 1'b0;
    c = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (mc_refresh) begin found = 1'b1; c = cyc; end
    end
    check("refresh_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_any_strobe(input logic client_only, output int c);
    logic found = 1'b0;
    c = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (mc_read || mc_write || (!client_only && mc_refresh)) begin found = 1'b1; c = cyc; end
    end
    check("strobe_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_ack(output int c);
    int a0 = ack_count;
    logic found = 1'b0;
    c = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (ack_count != a0) begin found = 1'b1; c = cyc; end
    end
    check("ack_seen", 32'(found), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 32'(cl_ack), 32'd0);
    check({tag, "_strobes"}, 32'({mc_read, mc_write, mc_refresh}), 32'd0);
    check({tag, "_addr"}, 32'(mc_addr), 32'd0);
    check({tag, "_din"}, mc_din, 32'd0);
    check({tag, "_wdm"}, 32'(mc_wdm), 32'd0);
    check({tag, "_rdata"}, cl_rdata, 32'd0);
    check({tag, "_overrun"}, 32'(refresh_overrun), 32'd0);
  endtask

  initial begin
    int c1, c2, s, a, a0;
    logic [N-1:0] seq [4];
    logic [N-1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    reset = 1'b1; cl_req = '0; cl_we = '0; cl_addr = '0; cl_wdata = '0; cl_wmask = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Idle bus: refresh every 840 cycles, no acks, no overrun.
    wait_refresh(c1);
    wait_refresh(c2);
    check("refresh_interval", 32'(c2 - c1), 32'd840);
    check("idle_no_ack", 32'(ack_count), 32'd0);
    check("idle_overrun", 32'(refresh_overrun), 32'd0);
    $display("txn refresh at cycles %0d and %0d", c1, c2);

    // Client 0 read.
    stub_dout = 32'hDEADBEEF;
    cl_we[0] = 1'b0; cl_addr[0*AW +: AW] = 23'h000123; cl_req[0] = 1'b1;
    wait_any_strobe(1'b1, s);
    check("rd_strobe", 32'({mc_read, mc_write}), 32'b10);
    check("rd_addr", 32'(mc_addr), 32'h000123);
    tick();
    check("rd_strobe_1cyc", 32'(mc_read), 32'd0);
    wait_ack(a);
    cl_req[0] = 1'b0;
    check("rd_ack", 32'(cl_ack), 32'b01);
    check("rd_data", cl_rdata, 32'hDEADBEEF);
    check("rd_latency", 32'(a - s), 32'd5);
    $display("txn read c0 addr=0x%06h data=0x%08h", 23'h000123, cl_rdata);
    tick();
    check("rd_ack_pulse", 32'(cl_ack), 32'd0);

    // Client 1 masked write; read data must not change.
    stub_dout = 32'h0BADF00D;
    cl_we[1] = 1'b1; cl_addr[1*AW +: AW] = 23'h000456;
    cl_wdata[1*DW +: DW] = 32'h11223344; cl_wmask[1*MW +: MW] = 4'b0101; cl_req[1] = 1'b1;
    wait_any_strobe(1'b1, s);
    check("wr_strobe", 32'({mc_read, mc_write}), 32'b01);
    check("wr_addr", 32'(mc_addr), 32'h000456);
    check("wr_din", mc_din, 32'h11223344);
    check("wr_wdm", 32'(mc_wdm), 32'b0101);
    wait_ack(a);
    cl_req[1] = 1'b0;
    check("wr_ack", 32'(cl_ack), 32'b10);
    check("wr_rdata_kept", cl_rdata, 32'hDEADBEEF);
    $display("txn write c1 addr=0x%06h data=0x11223344 mask=0101", 23'h000456);

    // Both clients request continuously: grants alternate.
    cl_we = '0; cl_addr[0*AW +: AW] = 23'h10; cl_addr[1*AW +: AW] = 23'h20;
    cl_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(a);
      seq[i] = last_ack;
      if (i == 3) cl_req = '0;
      $display("txn rr ack %0d -> 0b%02b", i, seq[i]);
    end
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

    // Controller held busy across two refresh wraps.
    wait_refresh(c1);
    repeat (830) tick();
    busy_force = 1'b1;
    stub_dout = 32'h5A5A5A5A;
    cl_we[0] = 1'b0; cl_addr[0*AW +: AW] = 23'h55; cl_req[0] = 1'b1;
    repeat (800) tick();
    check("ovr_before_2nd_wrap", 32'(refresh_overrun), 32'd0);
    repeat (100) tick();
    check("ovr_after_2nd_wrap", 32'(refresh_overrun), 32'd1);
    busy_force = 1'b0;
    wait_any_strobe(1'b0, s);
    check("ovr_refresh_first", 32'({mc_read, mc_write, mc_refresh}), 32'b001);
    wait_ack(a);
    cl_req[0] = 1'b0;
    check("ovr_ack", 32'(cl_ack), 32'b01);
    check("ovr_rdata", cl_rdata, 32'h5A5A5A5A);
    check("ovr_sticky", 32'(refresh_overrun), 32'd1);
    $display("txn read c0 after busy hold data=0x%08h overrun=%0b", cl_rdata, refresh_overrun);

    // Reset while waiting for completion.
    cl_addr[0*AW +: AW] = 23'h77; cl_req[0] = 1'b1;
    wait_any_strobe(1'b1, s);
    busy_force = 1'b1;
    repeat (3) tick();
    reset = 1'b1; cl_req = '0; busy_force = 1'b0;
    tick();
    reset = 1'b0;
    check_all_zero("midrst");
    a0 = ack_count;
    repeat (10) tick();
    check("midrst_no_ack", 32'(ack_count - a0), 32'd0);
    stub_dout = 32'hCAFEF00D;
    cl_we[1] = 1'b0; cl_addr[1*AW +: AW] = 23'h99; cl_req[1] = 1'b1;
    wait_any_strobe(1'b1, s);
    check("post_rst_addr", 32'(mc_addr), 32'h99);
    wait_ack(a);
    cl_req[1] = 1'b0;
    check("post_rst_ack", 32'(cl_ack), 32'b10);
    check("post_rst_rdata", cl_rdata, 32'hCAFEF00D);
    $display("txn read c1 after reset data=0x%08h", cl_rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
